// File: rtl/sblk_sched_pkg.sv
// sblk_sched_pkg
//   Shared definitions for the super-block row scheduler:
//   - instruction field widths (TN, TM, TP, LN, LP) and their total,
//   - default parameter values for the scheduler and its arbiter,
//   - the instruction FSM state encoding,
//   - a helper returning a safe index width for an N-entry vector.
package sblk_sched_pkg;

  // Instruction word field widths; the scheduler treats the word as opaque.
  localparam int INST_TN_W     = 3;
  localparam int INST_TM_W     = 3;
  localparam int INST_TP_W     = 2;
  localparam int INST_LN_W     = 3;
  localparam int INST_LP_W     = 3;
  localparam int INST_FIELDS_W = INST_TN_W + INST_TM_W + INST_TP_W + INST_LN_W + INST_LP_W;

  // Default configuration
  localparam int DEF_N_ROW         = 2;
  localparam int DEF_WID_ACT       = 16;
  localparam int DEF_ACT_BURST     = 4;
  localparam int DEF_START_TIMEOUT = 16;
  localparam int DEF_WID_CNT       = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_IDLE  = 2'd1,
    ISSUE      = 2'd2,
    WAIT_START = 2'd3
  } sched_state_e;

  // Index width that never collapses to zero bits (N=1 still gets one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sblk_rr_arb.sv
// sblk_rr_arb
//   Round-robin arbiter with burst hold for the shared activation stream.
//   A grant is taken only when none is held, searching cyclically from the
//   pointer; it is held for ACT_BURST transfers or until the granted row drops
//   its request. On release the pointer moves to the row after the granted one.
//   Because a new grant is only chosen while no grant is held, there is always
//   one bubble cycle between consecutive grants.
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   i_req  in   per-row request
//   i_vld  in   upstream beat valid
//   o_rdy  out  upstream beat ready (grant held and granted row requesting)
//   o_vld  out  one-hot valid towards the granted row
module sblk_rr_arb
  import sblk_sched_pkg::*;
#(
  parameter int N_ROW     = DEF_N_ROW,
  parameter int ACT_BURST = DEF_ACT_BURST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_ROW-1:0] i_req,
  input  logic             i_vld,
  output logic             o_rdy,
  output logic [N_ROW-1:0] o_vld
);

  localparam int IDX_W = idx_w(N_ROW);
  localparam int BST_W = $clog2(ACT_BURST + 1);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_gnt;
  logic             r_gnt_vld;
  logic [BST_W-1:0] r_bst;

  logic [IDX_W-1:0] w_pick;
  logic             w_found;
  logic             w_req_g;
  logic             w_xfer;
  logic             w_last;
  logic             w_release;
  logic [IDX_W-1:0] w_ptr_next;

  // Cyclic search for the first requester at or after the pointer.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] w_j;
    w_pick  = '0;
    w_found = 1'b0;
    j       = 0;
    w_j     = '0;
    for (int k = 0; k < N_ROW; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N_ROW) j = j - N_ROW;
      w_j = IDX_W'(j);
      if (!w_found && i_req[w_j]) begin
        w_found = 1'b1;
        w_pick  = w_j;
      end
    end
  end

  assign w_req_g    = i_req[r_gnt];
  assign o_rdy      = r_gnt_vld & w_req_g;
  assign w_xfer     = o_rdy & i_vld;
  assign w_last     = (r_bst == BST_W'(ACT_BURST - 1));
  // A request drop and a final beat cannot both advance the pointer: this is
  // a single release event either way.
  assign w_release  = r_gnt_vld & (~w_req_g | (w_xfer & w_last));
  assign w_ptr_next = (r_gnt == IDX_W'(N_ROW - 1)) ? '0 : r_gnt + IDX_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < N_ROW; gi++) begin : g_vld
      assign o_vld[gi] = w_xfer & (r_gnt == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_gnt_vld <= 1'b0;
      r_bst     <= '0;
    end else if (!r_gnt_vld) begin
      if (w_found) begin
        r_gnt_vld <= 1'b1;
        r_gnt     <= w_pick;
        r_bst     <= '0;
      end
    end else if (w_release) begin
      r_gnt_vld <= 1'b0;
      r_ptr     <= w_ptr_next;
      r_bst     <= '0;
    end else if (w_xfer) begin
      r_bst <= r_bst + BST_W'(1);
    end
  end

endmodule

// File: rtl/sblk_row_sched.sv
// sblk_row_sched
//   Controller in front of one super-block row array. Instructions tagged with
//   a row mask are issued only once all targeted rows are idle; the next
//   instruction is accepted only after those rows have reported busy. An
//   activation stream is shared among the rows through sblk_rr_arb.
//
//   Optional feature macro: SBLK_SCHED_TIMEOUT_EN
//     defined   - WAIT_START gives up after START_TIMEOUT cycles, sets the
//                 sticky sched_err and returns to IDLE.
//     undefined - WAIT_START waits indefinitely; sched_err is tied to 0.
//
// Ports:
//   clk_l            in   controller clock
//   rst              in   synchronous active-high reset
//   inst_in          in   instruction word
//   inst_row_mask    in   target rows (all-zero = consumed no-op)
//   inst_in_vld      in   instruction valid
//   inst_in_rdy      out  instruction ready (registered, high in IDLE)
//   inst_data        out  per-row instruction bus, row r at [r*WID_INST +: WID_INST]
//   inst_en          out  one-cycle issue strobe per row
//   status_sblk      in   per-row busy status
//   act_in           in   activation beat
//   act_in_vld       in   activation beat valid
//   act_in_rdy       out  activation beat consumed when vld&rdy
//   act_data_in      out  activation beat fanned out to every row
//   act_data_in_vld  out  one-hot valid to the granted row
//   act_data_in_req  in   per-row activation request
//   sched_idle       out  registered: FSM in IDLE and all rows idle
//   inst_cnt         out  issued-instruction counter (wraps)
//   sched_err        out  sticky start-timeout error
module sblk_row_sched
  import sblk_sched_pkg::*;
#(
  parameter int N_ROW         = DEF_N_ROW,
  parameter int WID_INST      = INST_FIELDS_W,
  parameter int WID_ACT       = DEF_WID_ACT,
  parameter int ACT_BURST     = DEF_ACT_BURST,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int WID_CNT       = DEF_WID_CNT
) (
  input  logic                         clk_l,
  input  logic                         rst,
  input  logic [WID_INST-1:0]          inst_in,
  input  logic [N_ROW-1:0]             inst_row_mask,
  input  logic                         inst_in_vld,
  output logic                         inst_in_rdy,
  output logic [WID_INST*N_ROW-1:0]    inst_data,
  output logic [N_ROW-1:0]             inst_en,
  input  logic [N_ROW-1:0]             status_sblk,
  input  logic [2*WID_ACT-1:0]         act_in,
  input  logic                         act_in_vld,
  output logic                         act_in_rdy,
  output logic [2*WID_ACT*N_ROW-1:0]   act_data_in,
  output logic [N_ROW-1:0]             act_data_in_vld,
  input  logic [N_ROW-1:0]             act_data_in_req,
  output logic                         sched_idle,
  output logic [WID_CNT-1:0]           inst_cnt,
  output logic                         sched_err
);

`ifdef SBLK_SCHED_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam int TO_W = $clog2(START_TIMEOUT + 1);

  sched_state_e        r_state;
  logic [WID_INST-1:0] r_inst;
  logic [N_ROW-1:0]    r_mask;
  logic                r_rdy;
  logic [N_ROW-1:0]    r_en;
  logic [WID_INST-1:0] r_data [N_ROW];
  logic [WID_CNT-1:0]  r_cnt;
  logic                r_idle;
  logic                r_err;
  logic [TO_W-1:0]     r_to_cnt;

  logic w_accept;
  logic w_rows_idle;
  logic w_rows_busy;
  logic w_issue_load;

  assign w_accept     = inst_in_vld & r_rdy;
  assign w_rows_idle  = ((status_sblk & r_mask) == '0);
  assign w_rows_busy  = ((status_sblk & r_mask) == r_mask);
  // The issue strobe and data are loaded on the WAIT_IDLE->ISSUE edge so that
  // they are visible while the FSM sits in ISSUE.
  assign w_issue_load = (r_state == WAIT_IDLE) & w_rows_idle;

  always_ff @(posedge clk_l) begin
    if (rst) begin
      r_state  <= IDLE;
      r_inst   <= '0;
      r_mask   <= '0;
      r_rdy    <= 1'b0;
      r_en     <= '0;
      r_cnt    <= '0;
      r_idle   <= 1'b0;
      r_err    <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_idle <= (r_state == IDLE) & (status_sblk == '0);
      case (r_state)
        IDLE: begin
          r_rdy <= 1'b1;
          // A zero mask is consumed in place: no issue, no count.
          if (w_accept && (inst_row_mask != '0)) begin
            r_inst  <= inst_in;
            r_mask  <= inst_row_mask;
            r_rdy   <= 1'b0;
            r_state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (w_rows_idle) begin
            r_en    <= r_mask;
            r_cnt   <= r_cnt + WID_CNT'(1);
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_en     <= '0;
          r_to_cnt <= '0;
          r_state  <= WAIT_START;
        end
        WAIT_START: begin
          if (w_rows_busy) begin
            r_rdy   <= 1'b1;
            r_state <= IDLE;
          end else if (TIMEOUT_EN && (r_to_cnt == TO_W'(START_TIMEOUT - 1))) begin
            r_err   <= 1'b1;
            r_rdy   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        default: begin
          r_rdy   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Per-row instruction slices: only masked rows take the new word, the
  // others keep whatever they were last issued.
  genvar gi;
  generate
    for (gi = 0; gi < N_ROW; gi++) begin : g_row
      always_ff @(posedge clk_l) begin
        if (rst) begin
          r_data[gi] <= '0;
        end else if (w_issue_load && r_mask[gi]) begin
          r_data[gi] <= r_inst;
        end
      end
      assign inst_data[gi*WID_INST +: WID_INST]       = r_data[gi];
      assign act_data_in[gi*2*WID_ACT +: 2*WID_ACT]   = act_in;
    end
  endgenerate

  assign inst_in_rdy = r_rdy;
  assign inst_en     = r_en;
  assign inst_cnt    = r_cnt;
  assign sched_idle  = r_idle;
  assign sched_err   = TIMEOUT_EN & r_err;

  sblk_rr_arb #(
    .N_ROW     (N_ROW),
    .ACT_BURST (ACT_BURST)
  ) u_arb (
    .clk   (clk_l),
    .rst   (rst),
    .i_req (act_data_in_req),
    .i_vld (act_in_vld),
    .o_rdy (act_in_rdy),
    .o_vld (act_data_in_vld)
  );

endmodule

// File: tb/tb_sblk_row_sched.sv
// tb_sblk_row_sched
//   Directed bench for sblk_row_sched (default parameters). Inputs are driven
//   1 time unit after the rising edge, outputs are compared 1 unit later.
//   The start-timeout expectations follow SBLK_SCHED_TIMEOUT_EN.
module tb_sblk_row_sched;

  logic        clk_l;
  logic        rst;
  logic [13:0] inst_in;
  logic [1:0]  inst_row_mask;
  logic        inst_in_vld;
  logic        inst_in_rdy;
  logic [27:0] inst_data;
  logic [1:0]  inst_en;
  logic [1:0]  status_sblk;
  logic [31:0] act_in;
  logic        act_in_vld;
  logic        act_in_rdy;
  logic [63:0] act_data_in;
  logic [1:0]  act_data_in_vld;
  logic [1:0]  act_data_in_req;
  logic        sched_idle;
  logic [15:0] inst_cnt;
  logic        sched_err;

  int n_checks = 0;
  int n_errs   = 0;

  sblk_row_sched dut (
    .clk_l           (clk_l),
    .rst             (rst),
    .inst_in         (inst_in),
    .inst_row_mask   (inst_row_mask),
    .inst_in_vld     (inst_in_vld),
    .inst_in_rdy     (inst_in_rdy),
    .inst_data       (inst_data),
    .inst_en         (inst_en),
    .status_sblk     (status_sblk),
    .act_in          (act_in),
    .act_in_vld      (act_in_vld),
    .act_in_rdy      (act_in_rdy),
    .act_data_in     (act_data_in),
    .act_data_in_vld (act_data_in_vld),
    .act_data_in_req (act_data_in_req),
    .sched_idle      (sched_idle),
    .inst_cnt        (inst_cnt),
    .sched_err       (sched_err)
  );

  initial clk_l = 1'b0;
  always #5 clk_l = ~clk_l;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_l);
    #1;
  endtask

  // Expected act_data_in_vld per cycle with both rows requesting, ACT_BURST=4.
  logic [1:0] t4_tab [13];

  initial begin
    t4_tab = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
               2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};

    rst             = 1'b1;
    inst_in         = '0;
    inst_row_mask   = '0;
    inst_in_vld     = 1'b0;
    status_sblk     = '0;
    act_in          = '0;
    act_in_vld      = 1'b0;
    act_data_in_req = '0;

    // ---------------- reset state
    repeat (3) tick();
    #1;
    check("rst_rdy",     64'(inst_in_rdy),     64'd0);
    check("rst_en",      64'(inst_en),         64'd0);
    check("rst_data",    64'(inst_data),       64'd0);
    check("rst_cnt",     64'(inst_cnt),        64'd0);
    check("rst_err",     64'(sched_err),       64'd0);
    check("rst_act_vld", 64'(act_data_in_vld), 64'd0);
    check("rst_act_rdy", 64'(act_in_rdy),      64'd0);
    tick();
    rst = 1'b0;
    tick();
    #1;
    check("post_rst_rdy",  64'(inst_in_rdy), 64'd1);
    check("post_rst_idle", 64'(sched_idle),  64'd1);

    // ---------------- test 1: mask 01, rows idle
    inst_in = 14'h1A5C; inst_row_mask = 2'b01; inst_in_vld = 1'b1;
    #1;
    check("t1_c0_rdy", 64'(inst_in_rdy), 64'd1);
    tick(); inst_in_vld = 1'b0; #1;
    check("t1_c1_en",  64'(inst_en),     64'd0);
    check("t1_c1_rdy", 64'(inst_in_rdy), 64'd0);
    tick(); #1;
    check("t1_c2_en",   64'(inst_en),          64'h1);
    check("t1_c2_row0", 64'(inst_data[13:0]),  64'h1A5C);
    check("t1_c2_row1", 64'(inst_data[27:14]), 64'h0);
    check("t1_c2_cnt",  64'(inst_cnt),         64'd1);
    tick(); status_sblk = 2'b01; #1;
    check("t1_c3_en",  64'(inst_en),     64'd0);
    check("t1_c3_rdy", 64'(inst_in_rdy), 64'd0);
    tick(); #1;
    check("t1_c4_rdy", 64'(inst_in_rdy), 64'd1);
    check("t1_c4_idle", 64'(sched_idle), 64'd0);
    status_sblk = 2'b00;
    tick(); tick(); #1;
    check("t1_idle", 64'(sched_idle), 64'd1);

    // ---------------- test 2: row1 busy until cycle 10
    status_sblk = 2'b10;
    inst_in = 14'h0F3D; inst_row_mask = 2'b10; inst_in_vld = 1'b1;
    #1;
    check("t2_c0_rdy", 64'(inst_in_rdy), 64'd1);
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) inst_in_vld = 1'b0;
      #1;
      check($sformatf("t2_c%0d_en", c), 64'(inst_en), 64'd0);
    end
    tick(); status_sblk = 2'b00; #1;
    check("t2_c10_en", 64'(inst_en), 64'd0);
    tick(); #1;
    check("t2_c11_en",   64'(inst_en),   64'h2);
    check("t2_c11_data", 64'(inst_data), 64'h3CF5A5C);
    check("t2_c11_cnt",  64'(inst_cnt),  64'd2);
    tick(); status_sblk = 2'b10; #1;
    tick(); #1;
    check("t2_c13_rdy", 64'(inst_in_rdy), 64'd1);
    status_sblk = 2'b00;

    // ---------------- test 3: zero mask is a consumed no-op
    inst_in = 14'h3FFF; inst_row_mask = 2'b00; inst_in_vld = 1'b1;
    tick(); inst_in_vld = 1'b0; #1;
    check("t3_rdy", 64'(inst_in_rdy), 64'd1);
    check("t3_en",  64'(inst_en),     64'd0);
    for (int c = 2; c <= 4; c++) begin
      tick(); #1;
      check($sformatf("t3_c%0d_en", c), 64'(inst_en), 64'd0);
    end
    check("t3_cnt",  64'(inst_cnt),  64'd2);
    check("t3_data", 64'(inst_data), 64'h3CF5A5C);

    // ---------------- start timeout: row0 never goes busy
    inst_in = 14'h0555; inst_row_mask = 2'b01; inst_in_vld = 1'b1;
    #1;
    check("to_c0_rdy", 64'(inst_in_rdy), 64'd1);
    tick(); inst_in_vld = 1'b0;
    tick(); #1;
    check("to_c2_en",  64'(inst_en),  64'h1);
    check("to_c2_cnt", 64'(inst_cnt), 64'd3);
    for (int c = 3; c <= 18; c++) tick();
    #1;
    check("to_c18_rdy", 64'(inst_in_rdy), 64'd0);
    check("to_c18_err", 64'(sched_err),   64'd0);
    tick(); #1;
`ifdef SBLK_SCHED_TIMEOUT_EN
    check("to_c19_err", 64'(sched_err),   64'd1);
    check("to_c19_rdy", 64'(inst_in_rdy), 64'd1);
    tick(); tick(); #1;
    check("to_err_sticky", 64'(sched_err), 64'd1);
`else
    check("to_c19_err", 64'(sched_err),   64'd0);
    check("to_c19_rdy", 64'(inst_in_rdy), 64'd0);
    status_sblk = 2'b01;
    tick(); #1;
    check("to_c20_rdy", 64'(inst_in_rdy), 64'd1);
    status_sblk = 2'b00;
`endif

    // ---------------- test 4: both rows request, bursts of 4 with a bubble
    tick();
    act_in_vld = 1'b1; act_data_in_req = 2'b11; act_in = 32'hA000_0000;
    #1;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) begin
        tick();
        act_in = 32'hA000_0000 + 32'(c);
        #1;
      end
      check($sformatf("t4_c%0d_vld", c), 64'(act_data_in_vld), 64'(t4_tab[c]));
      check($sformatf("t4_c%0d_rdy", c), 64'(act_in_rdy), 64'(t4_tab[c] != 2'b00));
      if (c == 2) check("t4_fanout", act_data_in, 64'hA000_0002_A000_0002);
    end

    // ---------------- reset mid-burst drops the grant and the instruction state
    tick(); rst = 1'b1;
    tick(); #1;
    check("mr_act_rdy", 64'(act_in_rdy),      64'd0);
    check("mr_act_vld", 64'(act_data_in_vld), 64'd0);
    check("mr_cnt",     64'(inst_cnt),        64'd0);
    check("mr_data",    64'(inst_data),       64'd0);
    check("mr_err",     64'(sched_err),       64'd0);
    rst = 1'b0;

    // ---------------- test 5: row0 drops its request after 2 beats
    tick(); #1;
    check("t5_c15_vld",  64'(act_data_in_vld), 64'h1);
    check("t5_c15_irdy", 64'(inst_in_rdy),     64'd1);
    tick(); #1;
    check("t5_c16_vld", 64'(act_data_in_vld), 64'h1);
    tick(); act_data_in_req = 2'b10; #1;
    check("t5_c17_vld", 64'(act_data_in_vld), 64'h0);
    check("t5_c17_rdy", 64'(act_in_rdy),      64'd0);
    tick(); act_data_in_req = 2'b11; #1;
    check("t5_c18_bubble", 64'(act_data_in_vld), 64'h0);
    tick(); #1;
    check("t5_c19_ptr_row1", 64'(act_data_in_vld), 64'h2);
    tick(); act_in_vld = 1'b0; #1;
    check("t5_c20_rdy", 64'(act_in_rdy),      64'd1);
    check("t5_c20_vld", 64'(act_data_in_vld), 64'h0);
    tick(); act_in_vld = 1'b1; #1;
    check("t5_c21_vld", 64'(act_data_in_vld), 64'h2);

    act_in_vld = 1'b0;
    act_data_in_req = 2'b00;
    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
